rtlfifordy1ck: RTL and testbench

Single-clock, parametrised successor of the dual-clock ready/valid FIFO. It buffers WIDTH-bit words between a producer and a request-driven consumer in one clock domain. On top of the earlier FIFO it adds configurable depth and width, an almost-full threshold, a read-enable gate, synchronous flush, per-cycle error pulses and an optional output register stage. It sits in front of the Keccak absorb path and in other same-clock datapaths that need elastic buffering with occupancy visibility.

---
 rtl/rtlfifo_pkg.sv | 29 ++
 rtl/rtlram1ck.sv | 52 +++++
 rtl/rtlfifordy1ck.sv | 165 ++++++++++++++++
 tb/tb_rtlfifordy1ck.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtlfifo_pkg.sv
// ----------------------------------------------------------------------------
// rtlfifo_pkg
// Shared definitions for the single-clock FIFO family (rtlfifordy1ck and its
// RAM). The package provides:
//   - RTLFIFO_AFULL_MARGIN : default distance of the almost-full threshold
//                            below DEPTH
//   - rtlfifo_len_w()      : width of an occupancy count for a given depth
//                            ($clog2(depth)+1, so that DEPTH itself fits)
//   - rtlfifo_len_t        : widest occupancy type the family supports
//   - is_pow2()            : elaboration-time depth check
// ----------------------------------------------------------------------------
package rtlfifo_pkg;

  localparam int unsigned RTLFIFO_AFULL_MARGIN = 4;
  localparam int unsigned RTLFIFO_LEN_MAX_W    = 32;

  typedef logic [RTLFIFO_LEN_MAX_W-1:0] rtlfifo_len_t;

  // Occupancy width for a FIFO of 'depth' entries: one more bit than the
  // address so that a completely full FIFO is representable.
  function automatic int unsigned rtlfifo_len_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/rtlram1ck.sv
// ----------------------------------------------------------------------------
// rtlram1ck
// Simple dual-port RAM, one write port and one read port, single clock,
// registered read. The storage array is never reset; only the read data
// register is, so the FIFO output comes up as zero.
// Ports:
//   clk      in   clock
//   rst_i    in   synchronous active-high reset of the read register
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable; rdata_o only changes when a read is issued
//   raddr_i  in   read address
//   rdata_o  out  registered read data
// ----------------------------------------------------------------------------
module rtlram1ck #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register holds its value between reads so the FIFO output is stable
  // while no word is being popped.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rtlfifordy1ck.sv
// ----------------------------------------------------------------------------
// rtlfifordy1ck
// Single-clock ready/valid FIFO with occupancy, almost-full threshold, read
// enable gate, synchronous flush and one-cycle error pulses.
// Optional feature macro: RTLFIFO_OUTREG_EN adds an output register stage
// (read latency 2 instead of 1).
// Ports:
//   clk        in   sole clock
//   rst        in   synchronous active-high reset
//   fifowr     in   write request          fifodi    in  write data
//   fifofull   out  occupancy == DEPTH     fifoafull out occupancy >= AFULL_TH
//   fifowrerr  out  pulse: write dropped (FIFO full)
//   reqen      in   read enable; masks fifordy and blocks pops
//   fifordy    out  reqen && not empty
//   fifoget    in   pop request
//   fifovld    out  fifodout carries a popped word this cycle
//   fifodout   out  read data, held while fifovld is low
//   fiforderr  out  pulse: pop dropped (not ready)
//   flush      in   synchronous clear of pointers and occupancy
//   fifolen    out  occupancy 0..DEPTH
//   fifowa     out  write address
// ----------------------------------------------------------------------------
module rtlfifordy1ck
  import rtlfifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned AFULL_TH = DEPTH - RTLFIFO_AFULL_MARGIN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fifowr,
  input  logic [WIDTH-1:0]              fifodi,
  output logic                          fifofull,
  output logic                          fifoafull,
  output logic                          fifowrerr,
  input  logic                          reqen,
  output logic                          fifordy,
  input  logic                          fifoget,
  output logic                          fifovld,
  output logic [WIDTH-1:0]              fifodout,
  output logic                          fiforderr,
  input  logic                          flush,
  output logic [$clog2(DEPTH):0]        fifolen,
  output logic [$clog2(DEPTH)-1:0]      fifowa
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = rtlfifo_len_w(DEPTH);

  // Elaboration checks on the configuration.
  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("rtlfifordy1ck: DEPTH must be a power of two >= 4");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("rtlfifordy1ck: AFULL_TH must lie in 1..DEPTH");
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        wrerr_q, wrerr_d;
  logic        rderr_q, rderr_d;
  logic        vld1_q, vld1_d;

  logic [LW-1:0]    len;
  logic             wr_acc;
  logic             pop_acc;
  logic [WIDTH-1:0] ram_rdata;

  assign len       = wptr_q - rptr_q;
  assign fifolen   = len;
  assign fifowa    = wptr_q[AW-1:0];
  assign fifofull  = (len == LW'(DEPTH));
  assign fifoafull = (len >= LW'(AFULL_TH));
  assign fifordy   = reqen && (len != '0);

  // Writes at full are dropped even if a pop frees a slot in the same cycle.
  assign wr_acc  = fifowr && !fifofull && !flush;
  assign pop_acc = fifoget && fifordy && !flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    wrerr_d = 1'b0;
    rderr_d = 1'b0;
    vld1_d  = 1'b0;
    if (flush) begin
      // Requests in the flush cycle are discarded silently.
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_acc) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (pop_acc) begin
        rptr_d = rptr_q + 1'b1;
      end
      wrerr_d = fifowr && fifofull;
      rderr_d = fifoget && !fifordy;
      vld1_d  = pop_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      wrerr_q <= 1'b0;
      rderr_q <= 1'b0;
      vld1_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      wrerr_q <= wrerr_d;
      rderr_q <= rderr_d;
      vld1_q  <= vld1_d;
    end
  end

  assign fifowrerr = wrerr_q;
  assign fiforderr = rderr_q;

  // A write never targets the slot being read: a same-cycle write can only
  // hit rptr when the FIFO is full, and writes at full are rejected.
  rtlram1ck #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst_i   (rst),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (fifodi),
    .re_i    (pop_acc),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

`ifdef RTLFIFO_OUTREG_EN
  logic             vld2_q;
  logic [WIDTH-1:0] dout2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld2_q  <= 1'b0;
      dout2_q <= '0;
    end else begin
      // Flush cancels the word sitting in the first stage as well.
      vld2_q <= vld1_q && !flush;
      if (vld1_q && !flush) begin
        dout2_q <= ram_rdata;
      end
    end
  end

  assign fifovld  = vld2_q;
  assign fifodout = dout2_q;
`else
  assign fifovld  = vld1_q;
  assign fifodout = ram_rdata;
`endif

endmodule

// File: tb/tb_rtlfifordy1ck.sv
module tb_rtlfifordy1ck;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 16;
  localparam int AFULL_TH = 12;
`ifdef RTLFIFO_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fifowr = 1'b0;
  logic [WIDTH-1:0] fifodi = '0;
  logic             fifofull;
  logic             fifoafull;
  logic             fifowrerr;
  logic             reqen = 1'b1;
  logic             fifordy;
  logic             fifoget = 1'b0;
  logic             fifovld;
  logic [WIDTH-1:0] fifodout;
  logic             fiforderr;
  logic             flush = 1'b0;
  logic [4:0]       fifolen;
  logic [3:0]       fifowa;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rtlfifordy1ck #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifowr    (fifowr),
    .fifodi    (fifodi),
    .fifofull  (fifofull),
    .fifoafull (fifoafull),
    .fifowrerr (fifowrerr),
    .reqen     (reqen),
    .fifordy   (fifordy),
    .fifoget   (fifoget),
    .fifovld   (fifovld),
    .fifodout  (fifodout),
    .fiforderr (fiforderr),
    .flush     (flush),
    .fifolen   (fifolen),
    .fifowa    (fifowa)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_v;
    int got_n;
    bit len_ok;
    bit wrapped;
    logic [3:0] prev_wa;

    // ---------------- reset ----------------
    tick();
    tick();
    rst = 1'b0;
    chk("rst_len", 32'(fifolen), 0);
    chk("rst_wa", 32'(fifowa), 0);
    chk("rst_vld", 32'(fifovld), 0);
    chk("rst_dout", fifodout, 0);
    chk("rst_wrerr", 32'(fifowrerr), 0);
    chk("rst_rderr", 32'(fiforderr), 0);
    chk("rst_rdy", 32'(fifordy), 0);
    chk("rst_full", 32'(fifofull), 0);

    // ---------------- single word ----------------
    fifowr = 1'b1; fifodi = 32'hDEADBEEF;
    tick();
    fifowr = 1'b0;
    chk("wr1_rdy", 32'(fifordy), 1);
    chk("wr1_len", 32'(fifolen), 1);
    fifoget = 1'b1;
    tick();
    fifoget = 1'b0;
    chk("pop1_len", 32'(fifolen), 0);
    for (int k = 1; k < RD_LAT; k++) begin
      chk("pop1_early_vld", 32'(fifovld), 0);
      tick();
    end
    chk("pop1_vld", 32'(fifovld), 1);
    chk("pop1_dout", fifodout, 32'hDEADBEEF);
    tick();
    chk("pop1_vld_drop", 32'(fifovld), 0);
    chk("pop1_dout_hold", fifodout, 32'hDEADBEEF);

    // ---------------- fill to full ----------------
    for (int i = 0; i < DEPTH; i++) begin
      fifowr = 1'b1; fifodi = 32'(i);
      tick();
      chk($sformatf("fill%0d_afull", i), 32'(fifoafull), (i + 1 >= AFULL_TH) ? 1 : 0);
    end
    fifowr = 1'b0;
    chk("fill_full", 32'(fifofull), 1);
    chk("fill_len", 32'(fifolen), 16);
    fifowr = 1'b1; fifodi = 32'h99;
    tick();
    fifowr = 1'b0;
    chk("ovf_wrerr", 32'(fifowrerr), 1);
    chk("ovf_len", 32'(fifolen), 16);
    tick();
    chk("ovf_wrerr_clr", 32'(fifowrerr), 0);

    // Drain; the first cycle also writes at full alongside the pop.
    exp_v = 0; got_n = 0;
    for (int c = 0; c < DEPTH + 4; c++) begin
      fifoget = (c < DEPTH);
      fifowr  = (c == 0);
      fifodi  = 32'h77;
      tick();
      if (c == 0) begin
        chk("fullpop_wrerr", 32'(fifowrerr), 1);
        chk("fullpop_len", 32'(fifolen), 15);
      end
      if (fifovld) begin
        chk($sformatf("drain%0d_dout", got_n), fifodout, 32'(exp_v));
        exp_v++; got_n++;
      end
    end
    fifoget = 1'b0; fifowr = 1'b0;
    chk("drain_count", 32'(got_n), 16);
    chk("drain_len", 32'(fifolen), 0);

    // ---------------- steady wr+get at len 5 ----------------
    for (int i = 0; i < 5; i++) begin
      fifowr = 1'b1; fifodi = 32'(100 + i);
      tick();
    end
    exp_v = 100; got_n = 0; len_ok = 1'b1; wrapped = 1'b0; prev_wa = fifowa;
    for (int c = 0; c < 40; c++) begin
      fifowr = 1'b1; fifoget = 1'b1; fifodi = 32'(105 + c);
      tick();
      if (fifolen != 5) len_ok = 1'b0;
      if (prev_wa == 4'd15 && fifowa == 4'd0) wrapped = 1'b1;
      prev_wa = fifowa;
      if (fifovld) begin
        chk($sformatf("steady%0d_dout", got_n), fifodout, 32'(exp_v));
        exp_v++; got_n++;
      end
    end
    fifowr = 1'b0;
    for (int c = 0; c < 5 + 3; c++) begin
      fifoget = (c < 5);
      tick();
      if (fifovld) begin
        chk($sformatf("steady%0d_dout", got_n), fifodout, 32'(exp_v));
        exp_v++; got_n++;
      end
    end
    fifoget = 1'b0;
    chk("steady_len_const", 32'(len_ok), 1);
    chk("steady_wa_wrap", 32'(wrapped), 1);
    chk("steady_count", 32'(got_n), 45);
    chk("steady_len_end", 32'(fifolen), 0);

    // ---------------- pop errors ----------------
    fifoget = 1'b1;
    tick();
    fifoget = 1'b0;
    chk("empty_rderr", 32'(fiforderr), 1);
    chk("empty_len", 32'(fifolen), 0);
    tick();
    chk("empty_rderr_clr", 32'(fiforderr), 0);
    chk("empty_vld", 32'(fifovld), 0);
    for (int i = 0; i < 3; i++) begin
      fifowr = 1'b1; fifodi = 32'(200 + i);
      tick();
    end
    fifowr = 1'b0;
    reqen = 1'b0;
    #1;
    chk("noreq_rdy", 32'(fifordy), 0);
    fifoget = 1'b1;
    tick();
    fifoget = 1'b0;
    chk("noreq_rderr", 32'(fiforderr), 1);
    chk("noreq_len", 32'(fifolen), 3);
    tick();
    chk("noreq_rderr_clr", 32'(fiforderr), 0);
    chk("noreq_vld", 32'(fifovld), 0);
    reqen = 1'b1;

    // ---------------- flush ----------------
    for (int i = 0; i < 5; i++) begin
      fifowr = 1'b1; fifodi = 32'(300 + i);
      tick();
    end
    fifowr = 1'b0;
    fifoget = 1'b1;
    tick();
    chk("preflush_len", 32'(fifolen), 7);
    flush = 1'b1; fifowr = 1'b1; fifoget = 1'b1;
    tick();
    flush = 1'b0; fifowr = 1'b0; fifoget = 1'b0;
    chk("flush_len", 32'(fifolen), 0);
    chk("flush_wa", 32'(fifowa), 0);
    chk("flush_rdy", 32'(fifordy), 0);
    chk("flush_vld", 32'(fifovld), 0);
    chk("flush_wrerr", 32'(fifowrerr), 0);
    chk("flush_rderr", 32'(fiforderr), 0);
    tick();
    chk("flush_vld_next", 32'(fifovld), 0);
    chk("flush_len_next", 32'(fifolen), 0);

    // ---------------- reset mid-burst ----------------
    for (int i = 0; i < 4; i++) begin
      fifowr = 1'b1; fifodi = 32'(400 + i);
      tick();
    end
    fifoget = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fifodi = 32'(500 + i);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; fifowr = 1'b0; fifoget = 1'b0;
    chk("brst_len", 32'(fifolen), 0);
    chk("brst_wa", 32'(fifowa), 0);
    chk("brst_vld", 32'(fifovld), 0);
    chk("brst_dout", fifodout, 0);
    chk("brst_wrerr", 32'(fifowrerr), 0);
    chk("brst_rderr", 32'(fiforderr), 0);
    chk("brst_rdy", 32'(fifordy), 0);
    fifowr = 1'b1; fifodi = 32'hA5A5A5A5;
    tick();
    fifowr = 1'b0;
    chk("post_rst_wa", 32'(fifowa), 1);
    chk("post_rst_len", 32'(fifolen), 1);
    fifoget = 1'b1;
    tick();
    fifoget = 1'b0;
    for (int k = 1; k < RD_LAT; k++) tick();
    chk("post_rst_vld", 32'(fifovld), 1);
    chk("post_rst_dout", fifodout, 32'hA5A5A5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
